// File: rtl/alarm_bank.sv
// alarm_bank: multi-channel BCD alarm unit with a ring/snooze FSM per channel.
// Optional snooze support is compiled in when ALARM_SNOOZE_EN is defined;
// without it each channel only moves between IDLE and RING.
module alarm_bank #(
    parameter int N_ALARMS    = 4,
    parameter int CH_W        = 2,
    parameter int HOURS_24    = 0,
    parameter int RING_SECS   = 16,
    parameter int SNOOZE_SECS = 60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_1hz,
    input  logic [19:0]         present_time,
    input  logic                edit_en,
    input  logic [CH_W-1:0]     edit_ch,
    input  logic [2:0]          edit_field,
    input  logic                edit_inc,
    input  logic                arm_toggle,
    input  logic                stop,
    input  logic                snooze,
    output logic [19:0]         al_time_rd,
    output logic [N_ALARMS-1:0] armed,
    output logic [N_ALARMS-1:0] ring,
    output logic                any_ring
);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;
`else
    typedef enum logic {S_IDLE, S_RING} state_t;
`endif

    localparam logic [1:0] MAX_H10 = (HOURS_24 != 0) ? 2'd2 : 2'd1;

    logic [N_ALARMS-1:0][19:0] al_time;
    logic [N_ALARMS-1:0]       ring_nxt;
    logic                      edit_hit;

    // An hour is invalid past 11 (12h) or past 23 (24h)
    function automatic logic hour_bad(input logic [1:0] h10, input logic [3:0] h);
        if (HOURS_24 != 0) hour_bad = (h10 == 2'd2) && (h > 4'd3);
        else               hour_bad = (h10 == 2'd1) && (h > 4'd1);
    endfunction

    // Increment one BCD digit in place; no carry into neighbouring digits
    function automatic logic [19:0] bump(input logic [19:0] t, input logic [2:0] f);
        logic [19:0] r;
        logic [3:0]  d;
        logic [1:0]  h10n;
        r = t;
        case (f)
            3'd0: r[3:0]   = (t[3:0]   >= 4'd9) ? 4'd0 : t[3:0]   + 4'd1;
            3'd1: r[6:4]   = (t[6:4]   >= 3'd5) ? 3'd0 : t[6:4]   + 3'd1;
            3'd2: r[10:7]  = (t[10:7]  >= 4'd9) ? 4'd0 : t[10:7]  + 4'd1;
            3'd3: r[13:11] = (t[13:11] >= 3'd5) ? 3'd0 : t[13:11] + 3'd1;
            3'd4: begin
                d = (t[17:14] >= 4'd9) ? 4'd0 : t[17:14] + 4'd1;
                if (hour_bad(t[19:18], d)) d = 4'd0;
                r[17:14] = d;
            end
            3'd5: begin
                h10n = (t[19:18] >= MAX_H10) ? 2'd0 : t[19:18] + 2'd1;
                r[19:18] = h10n;
                if (hour_bad(h10n, t[17:14])) r[17:14] = 4'd0;
            end
            default: r = t;
        endcase
        return r;
    endfunction

    assign edit_hit = int'(edit_ch) < N_ALARMS;

    // Combinational read-back of the channel being edited
    always_comb begin
        al_time_rd = '0;
        if (edit_hit) al_time_rd = al_time[edit_ch];
    end

    // Alarm time storage and arm flags
    always_ff @(posedge clk) begin
        if (rst) begin
            al_time <= '0;
            armed   <= '0;
        end else begin
            if (edit_en && edit_inc && edit_hit)
                al_time[edit_ch] <= bump(al_time[edit_ch], edit_field);
            if (arm_toggle && edit_hit)
                armed[edit_ch] <= ~armed[edit_ch];
        end
    end

    for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
        state_t     st, st_nxt;
        logic [7:0] cnt, cnt_nxt;
        logic       match, disarm;

        assign match  = tick_1hz && armed[i] && (present_time == al_time[i]);
        assign disarm = arm_toggle && edit_hit && (int'(edit_ch) == i) && armed[i];

        // Next-state: stop beats disarm beats snooze beats tick/match
        always_comb begin
            st_nxt  = st;
            cnt_nxt = cnt;
            if (stop || disarm) begin
                st_nxt  = S_IDLE;
                cnt_nxt = '0;
            end else begin
                case (st)
                    S_IDLE: if (match) begin
                        st_nxt  = S_RING;
                        cnt_nxt = '0;
                    end
                    S_RING: begin
`ifdef ALARM_SNOOZE_EN
                        if (snooze) begin
                            st_nxt  = S_SNOOZE;
                            cnt_nxt = '0;
                        end else
`endif
                        if (tick_1hz) begin
                            if (cnt == 8'(RING_SECS - 1)) begin
                                st_nxt  = S_IDLE;
                                cnt_nxt = '0;
                            end else begin
                                cnt_nxt = cnt + 8'd1;
                            end
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    S_SNOOZE: if (tick_1hz) begin
                        if (cnt == 8'(SNOOZE_SECS - 1)) begin
                            st_nxt  = S_RING;
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = cnt + 8'd1;
                        end
                    end
`endif
                    default: begin
                        st_nxt  = S_IDLE;
                        cnt_nxt = '0;
                    end
                endcase
            end
        end

        // Channel state register
        always_ff @(posedge clk) begin
            if (rst) begin
                st  <= S_IDLE;
                cnt <= '0;
            end else begin
                st  <= st_nxt;
                cnt <= cnt_nxt;
            end
        end

        assign ring_nxt[i] = (st_nxt == S_RING);
    end

`ifndef ALARM_SNOOZE_EN
    logic       unused_snooze;
    logic [7:0] unused_snooze_secs;
    assign unused_snooze      = snooze;
    assign unused_snooze_secs = 8'(SNOOZE_SECS);
`endif

    // Registered ring outputs, derived from next state so they track the FSM exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            ring     <= '0;
            any_ring <= 1'b0;
        end else begin
            ring     <= ring_nxt;
            any_ring <= |ring_nxt;
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: one 12h and one 24h instance share all inputs.
module tb_alarm_bank;
    logic        clk = 1'b0;
    logic        rst, tick_1hz, edit_en, edit_inc, arm_toggle, stop, snooze;
    logic [19:0] present_time;
    logic [1:0]  edit_ch;
    logic [2:0]  edit_field;
    logic [19:0] al_time_rd, al_time_rd24;
    logic [3:0]  armed, ring, armed24, ring24;
    logic        any_ring, any_ring24;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alarm_bank #(.HOURS_24(0)) u_dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .present_time(present_time),
        .edit_en(edit_en), .edit_ch(edit_ch), .edit_field(edit_field), .edit_inc(edit_inc),
        .arm_toggle(arm_toggle), .stop(stop), .snooze(snooze),
        .al_time_rd(al_time_rd), .armed(armed), .ring(ring), .any_ring(any_ring)
    );

    alarm_bank #(.HOURS_24(1)) u_dut24 (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .present_time(present_time),
        .edit_en(edit_en), .edit_ch(edit_ch), .edit_field(edit_field), .edit_inc(edit_inc),
        .arm_toggle(arm_toggle), .stop(stop), .snooze(snooze),
        .al_time_rd(al_time_rd24), .armed(armed24), .ring(ring24), .any_ring(any_ring24)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] mk(input int h10, input int h, input int m10,
                                       input int m, input int s10, input int s);
        return {h10[1:0], h[3:0], m10[2:0], m[3:0], s10[2:0], s[3:0]};
    endfunction

    task automatic inc(input int ch, input int f, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            edit_ch = ch[1:0]; edit_field = f[2:0]; edit_en = 1'b1; edit_inc = 1'b1;
        end
        @(negedge clk);
        edit_en = 1'b0; edit_inc = 1'b0;
    endtask

    task automatic arm(input int ch);
        @(negedge clk);
        edit_ch = ch[1:0]; arm_toggle = 1'b1;
        @(negedge clk);
        arm_toggle = 1'b0;
    endtask

    // one clock with optional tick/stop/snooze pulses
    task automatic cyc(input logic tk, input logic [19:0] t, input logic sp, input logic sn);
        @(negedge clk);
        tick_1hz = tk; present_time = t; stop = sp; snooze = sn;
        @(negedge clk);
        tick_1hz = 1'b0; stop = 1'b0; snooze = 1'b0;
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [19:0] t5, tx;

    initial begin
        rst = 1'b1; tick_1hz = 0; edit_en = 0; edit_inc = 0; arm_toggle = 0;
        stop = 0; snooze = 0; present_time = '0; edit_ch = '0; edit_field = '0;
        t5 = mk(0, 0, 0, 0, 0, 5);
        tx = mk(0, 0, 0, 0, 0, 6);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_armed", 32'(armed), 32'h0);
        chk("rst_ring", 32'(ring), 32'h0);
        chk("rst_any", 32'(any_ring), 32'h0);
        chk("rst_time", 32'(al_time_rd), 32'h0);

        // digit editing, wrap without carry, no-op field
        inc(2, 1, 7);
        inc(2, 4, 3);
        inc(2, 6, 2);
        edit_ch = 2'd2; #1;
        chk("edit_ch2", 32'(al_time_rd), 32'(mk(0, 3, 0, 0, 1, 0)));
        inc(2, 0, 10);
        inc(2, 2, 12);
        edit_ch = 2'd2; #1;
        chk("wrap_s_m", 32'(al_time_rd), 32'(mk(0, 3, 0, 2, 1, 0)));
        edit_ch = 2'd0; #1;
        chk("ch0_untouched", 32'(al_time_rd), 32'h0);

        // hour wrap rules
        inc(1, 5, 1);
        inc(1, 4, 2);
        edit_ch = 2'd1; #1;
        chk("h12_wrap", 32'(al_time_rd), 32'(mk(1, 0, 0, 0, 0, 0)));
        chk("h24_no_wrap", 32'(al_time_rd24), 32'(mk(1, 2, 0, 0, 0, 0)));
        inc(3, 4, 5);
        inc(3, 5, 2);
        edit_ch = 2'd3; #1;
        chk("h24_h10_force", 32'(al_time_rd24), 32'(mk(2, 0, 0, 0, 0, 0)));
        chk("h12_h10_force", 32'(al_time_rd), 32'(mk(0, 0, 0, 0, 0, 0)));

        // single ring lasting 16 ticks
        do_rst();
        chk("rst2_time", 32'(al_time_rd), 32'h0);
        inc(0, 0, 5);
        arm(0);
        chk("armed0", 32'(armed), 32'h1);
        cyc(1, mk(0, 0, 0, 0, 0, 4), 0, 0);
        chk("no_match", 32'(ring), 32'h0);
        cyc(1, t5, 0, 0);
        chk("ring0", 32'(ring), 32'h1);
        chk("any0", 32'(any_ring), 32'h1);
        cyc(0, t5, 0, 0);
        chk("ring0_hold", 32'(ring), 32'h1);
        for (int k = 0; k < 15; k++) cyc(1, tx, 0, 0);
        chk("ring0_15", 32'(ring), 32'h1);
        cyc(1, tx, 0, 0);
        chk("ring0_end", 32'(ring), 32'h0);
        chk("any0_end", 32'(any_ring), 32'h0);

        // two channels together, stop
        inc(1, 0, 5);
        arm(1);
        cyc(1, t5, 0, 0);
        chk("ring01", 32'(ring), 32'h3);
        cyc(1, t5, 0, 0);
        chk("ring01_norestart", 32'(ring), 32'h3);
        cyc(0, tx, 1, 0);
        chk("stop01", 32'(ring), 32'h0);
        cyc(1, t5, 1, 0);
        chk("stop_on_match", 32'(ring), 32'h0);
        chk("stop_any", 32'(any_ring), 32'h0);

        // snooze
        cyc(1, t5, 0, 0);
        chk("ring_pre_snz", 32'(ring), 32'h3);
        cyc(0, tx, 0, 1);
`ifdef ALARM_SNOOZE_EN
        chk("snz_quiet", 32'(ring), 32'h0);
        for (int k = 0; k < 59; k++) cyc(1, tx, 0, 0);
        chk("snz_59", 32'(ring), 32'h0);
        cyc(1, tx, 0, 0);
        chk("snz_60", 32'(ring), 32'h3);
`else
        chk("snz_noop", 32'(ring), 32'h3);
`endif
        cyc(0, tx, 1, 0);
        chk("snz_stop", 32'(ring), 32'h0);

        // disarm ringing channel, then reset mid-ring
        inc(3, 0, 5);
        arm(3);
        cyc(1, t5, 0, 0);
        chk("ring013", 32'(ring), 32'hB);
        arm(3);
        chk("disarm3_ring", 32'(ring), 32'h3);
        chk("disarm3_armed", 32'(armed), 32'h3);
        do_rst();
        chk("rst_mid_ring", 32'(ring), 32'h0);
        chk("rst_mid_any", 32'(any_ring), 32'h0);
        chk("rst_mid_armed", 32'(armed), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
